// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer: merges stall, redirect, memory-wait and interrupt requests into stage controls.
// Optional STALL_PERF_CNT_EN macro adds stall_cycles / flush_count performance counters.
module pipeline_stall_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int DRAIN_CYC   = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             mem_busy,
    input  logic             irq,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       pc_sel,
    output logic             irq_ack,
    output logic             mem_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [2:0] {INIT, RUN, MEMWAIT, DRAIN, ENTER} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n, drain_cnt, drain_cnt_n;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= INIT;
            wait_cnt    <= '0;
            drain_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            drain_cnt   <= drain_cnt_n;
            mem_timeout <= mem_timeout | (state_n == MEMWAIT && wait_cnt_n == TIMEOUT);
        end

    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        drain_cnt_n = drain_cnt;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = 2'b00;
        irq_ack     = 1'b0;
        case (state)
            INIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_n     = RUN;
            end
            // a released memory wait falls straight through to the normal priority chain
            RUN, MEMWAIT: begin
                state_n = RUN;
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_n     = MEMWAIT;
                    wait_cnt_n  = (state == RUN) ? ONE : (wait_cnt == '1 ? wait_cnt : wait_cnt + ONE);
                end else if (branch_taken) begin
                    pc_sel      = 2'b01;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (jump_id) begin
                    pc_sel      = 2'b10;
                    if_id_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (irq) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    drain_cnt_n = ONE;
                    state_n     = (ONE >= DRAIN_END) ? ENTER : DRAIN;
                end
            end
            DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if (!mem_busy) begin
                    id_ex_flush = 1'b1;
                    drain_cnt_n = drain_cnt + ONE;
                    state_n     = (drain_cnt_n >= DRAIN_END) ? ENTER : DRAIN;
                end
            end
            ENTER: begin
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end else begin
                    pc_sel      = 2'b11;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    irq_ack     = 1'b1;
                    state_n     = RUN;
                end
            end
            default: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                state_n     = INIT;
            end
        endcase
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (state != INIT) begin
            if (!pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + ONE;
            if (if_id_flush && flush_count != '1) flush_count <= flush_count + ONE;
        end
`endif
endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb_pipeline_stall_sequencer: vector table, memory-timeout sequence and random stimulus
// against a priority-rule reference model.
module tb_pipeline_stall_sequencer;
    localparam int CNT_W = 16, MEM_TIMEOUT = 255, DRAIN_CYC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1, load_use = 1'b0, branch_taken = 1'b0, jump_id = 1'b0, mem_busy = 1'b0, irq = 1'b0;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, irq_ack, mem_timeout;
    logic [1:0] pc_sel;
    logic [7:0] act;
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    pipeline_stall_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .load_use(load_use), .branch_taken(branch_taken), .jump_id(jump_id),
        .mem_busy(mem_busy), .irq(irq), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pc_sel(pc_sel), .irq_ack(irq_ack),
        .mem_timeout(mem_timeout)
`ifdef STALL_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    assign act = {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel, irq_ack, mem_timeout};

    int checks = 0, errors = 0;

    // reference model: boot flag, interrupt-in-progress with bubbles issued, consecutive busy cycles
    bit m_boot = 1'b1, m_irq = 1'b0, m_to = 1'b0;
    int m_drained = 0, m_busy_run = 0, m_stall = 0, m_flush = 0;

    task automatic model_step(input logic [5:0] in, output logic [7:0] e);
        logic r, lu, br, jp, bz, iq;
        bit was_boot;
        {r, lu, br, jp, bz, iq} = in;
        if (r) begin
            m_boot = 1'b1; m_irq = 1'b0; m_to = 1'b0;
            m_drained = 0; m_busy_run = 0; m_stall = 0; m_flush = 0;
        end
        was_boot = m_boot;
        e = {7'b1100000, m_to};
        if (m_boot) begin
            e[7:1] = 7'b0011000;
            m_boot = r;
        end else if (m_irq) begin
            m_busy_run = 0;
            if (bz) e[7:1] = 7'b0000000;
            else if (m_drained < DRAIN_CYC) begin e[7:1] = 7'b0001000; m_drained++; end
            else begin e[7:1] = 7'b1111111; m_irq = 1'b0; end
        end else begin
            m_busy_run = bz ? m_busy_run + 1 : 0;
            if (bz) e[7:1] = 7'b0000000;
            else if (br) e[7:1] = 7'b1111010;
            else if (jp) e[7:1] = 7'b1110100;
            else if (lu) e[7:1] = 7'b0001000;
            else if (iq) begin e[7:1] = 7'b0001000; m_irq = 1'b1; m_drained = 1; end
        end
        if (m_busy_run == MEM_TIMEOUT) m_to = 1'b1;
        if (!was_boot && !e[7]) m_stall++;
        if (!was_boot && e[5]) m_flush++;
    endtask

    task automatic step(input logic [5:0] in);
        logic [7:0] e;
        @(negedge clk);
        {reset, load_use, branch_taken, jump_id, mem_busy, irq} = in;
        #1;
        model_step(in, e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL model t=%0t in=%b got=%b exp=%b", $time, in, act, e);
        end
    endtask

    typedef struct { logic [5:0] in; logic [6:0] exp; } vec_t;
    vec_t tbl [27];

    initial begin
        // inputs {reset,load_use,branch,jump,busy,irq}; outputs {pcw,ifw,iff,ief,sel,ack}
        tbl[0]  = '{6'b100000, 7'b0011000};
        tbl[1]  = '{6'b000000, 7'b0011000};
        tbl[2]  = '{6'b000000, 7'b1100000};
        tbl[3]  = '{6'b000000, 7'b1100000};
        tbl[4]  = '{6'b010000, 7'b0001000};
        tbl[5]  = '{6'b000000, 7'b1100000};
        tbl[6]  = '{6'b011100, 7'b1111010};
        tbl[7]  = '{6'b000100, 7'b1110100};
        tbl[8]  = '{6'b000001, 7'b0001000};
        tbl[9]  = '{6'b000001, 7'b0001000};
        tbl[10] = '{6'b000000, 7'b1111111};
        tbl[11] = '{6'b000000, 7'b1100000};
        tbl[12] = '{6'b000001, 7'b0001000};
        tbl[13] = '{6'b000010, 7'b0000000};
        tbl[14] = '{6'b000000, 7'b0001000};
        tbl[15] = '{6'b000010, 7'b0000000};
        tbl[16] = '{6'b000000, 7'b1111111};
        tbl[17] = '{6'b001010, 7'b0000000};
        tbl[18] = '{6'b000010, 7'b0000000};
        tbl[19] = '{6'b001000, 7'b1111010};
        tbl[20] = '{6'b000001, 7'b0001000};
        tbl[21] = '{6'b100000, 7'b0011000};
        tbl[22] = '{6'b000000, 7'b0011000};
        tbl[23] = '{6'b000000, 7'b1100000};
        tbl[24] = '{6'b010001, 7'b0001000};
        tbl[25] = '{6'b000101, 7'b1110100};
        tbl[26] = '{6'b000000, 7'b1100000};

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].in);
            checks++;
            if (act[7:1] !== tbl[i].exp) begin
                errors++;
                $display("FAIL tbl[%0d] got=%b exp=%b", i, act[7:1], tbl[i].exp);
            end
        end

        // long memory wait: flag appears once 255 busy clocks have elapsed and sticks
        for (int k = 1; k <= 300; k++) begin
            step(6'b000010);
            if (k == 255 || k == 256) begin
                checks++;
                if (mem_timeout !== (k == 256)) begin
                    errors++;
                    $display("FAIL timeout_edge k=%0d got=%b exp=%b", k, mem_timeout, k == 256);
                end
            end
        end
        step(6'b000000);
        checks++;
        if (mem_timeout !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b/%b exp=1/1", mem_timeout, pc_write);
        end
        step(6'b100000);
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reset got=%b exp=0", mem_timeout);
        end

        for (int n = 0; n < 3000; n++)
            step({$urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0});

`ifdef STALL_PERF_CNT_EN
        @(negedge clk);
        checks++;
        if (stall_cycles !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush)) begin
            errors++;
            $display("FAIL perf got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count, m_stall, m_flush);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
